alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_op_core.sv | 77 +++++++
 rtl/alu_exec_stage.sv | 94 +++++++++
 tb/tb_alu_exec_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state encodings shared by the ALU execute stage
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SUB  = 2'd0,
    OP_NAND = 2'd1,
    OP_ONES = 2'd2,
    OP_DEC  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_core.sv
// rtl/alu_op_core.sv - combinational operation select for the ALU execute stage
module alu_op_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN   = 8
) (
  input  alu_op_e          op,
  input  logic [LEN-1:0]   a,
  input  logic [LEN-1:0]   b,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             err
);

  localparam int OW = 2 * WIDTH;
  localparam int DW = 2 * LEN;

  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [WIDTH-1:0] diff;
  logic [OW-1:0]    ones_vec;
  logic [DW-1:0]    dec_vec;
  logic             multi_hot;
  logic             run;
  logic             found;
  int               ones_cnt;
  int               dec_idx;

  assign a_w       = a[WIDTH-1:0];
  assign b_w       = b[WIDTH-1:0];
  assign diff      = a_w - b_w;
  assign ones_vec  = {b_w, a_w};
  assign dec_vec   = {b, a};
  assign multi_hot = |(dec_vec & (dec_vec - {{(DW-1){1'b0}}, 1'b1}));

  // Leading-ones run from the MSB, and lowest-set-bit index of the wide vector
  always_comb begin
    ones_cnt = 0;
    run      = 1'b1;
    for (int i = OW - 1; i >= 0; i--) begin
      if (run && ones_vec[i]) ones_cnt = ones_cnt + 1;
      else run = 1'b0;
    end
    dec_idx = 0;
    found   = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (!found && dec_vec[i]) begin
        dec_idx = i;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    y        = '0;
    overflow = 1'b0;
    err      = 1'b0;
    case (op)
      OP_SUB: begin
        y        = diff;
        overflow = (a_w[WIDTH-1] != b_w[WIDTH-1]) && (diff[WIDTH-1] != a_w[WIDTH-1]);
      end
      OP_NAND: y = ~(a_w & b_w);
      OP_ONES: begin
        y        = ones_cnt[WIDTH-1:0];
        overflow = ones_cnt > (2 ** WIDTH - 1);
      end
      OP_DEC: begin
        y        = dec_idx[WIDTH-1:0];
        overflow = dec_idx > (2 ** WIDTH - 1);
        err      = multi_hot;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - three-state ALU execute stage with sticky flags and op counter
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [LEN-1:0]   i_a,
  input  logic [LEN-1:0]   i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_overflow,
  output logic             o_err,
  output logic             o_sticky_ovf,
  output logic             o_sticky_err,
  input  logic             i_clr_status,
  output logic [7:0]       o_op_count
);

  state_e           state;
  alu_op_e          op_q;
  logic [LEN-1:0]   a_q;
  logic [LEN-1:0]   b_q;
  logic [WIDTH-1:0] core_y;
  logic             core_ovf;
  logic             core_err;

  alu_op_core #(.WIDTH(WIDTH), .LEN(LEN)) u_core (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .y        (core_y),
    .overflow (core_ovf),
    .err      (core_err)
  );

  assign o_ready = (state == ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_SUB;
      a_q          <= '0;
      b_q          <= '0;
      o_valid      <= 1'b0;
      o_y          <= '0;
      o_overflow   <= 1'b0;
      o_err        <= 1'b0;
      o_sticky_ovf <= 1'b0;
      o_sticky_err <= 1'b0;
      o_op_count   <= 8'd0;
    end else begin
      if (i_clr_status) begin
        o_sticky_ovf <= 1'b0;
        o_sticky_err <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            op_q  <= alu_op_e'(i_op);
            a_q   <= i_a;
            b_q   <= i_b;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          o_y          <= core_y;
          o_overflow   <= core_ovf;
          o_err        <= core_err;
          // A coincident clear still lets this result's flags through
          o_sticky_ovf <= (o_sticky_ovf & ~i_clr_status) | core_ovf;
          o_sticky_err <= (o_sticky_err & ~i_clr_status) | core_err;
          o_op_count   <= o_op_count + 8'd1;
          o_valid      <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage (WIDTH=4, LEN=8)
module tb_alu_exec_stage;

  typedef struct packed {
    logic [3:0] y;
    logic       ovf;
    logic       err;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [1:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_y;
  logic       o_overflow;
  logic       o_err;
  logic       o_sticky_ovf;
  logic       o_sticky_err;
  logic       i_clr_status;
  logic [7:0] o_op_count;

  int   checks = 0;
  int   passes = 0;
  exp_t sb_q[$];
  exp_t held;
  logic [7:0] exp_count;

  alu_exec_stage #(.WIDTH(4), .LEN(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_op         (i_op),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_y          (o_y),
    .o_overflow   (o_overflow),
    .o_err        (o_err),
    .o_sticky_ovf (o_sticky_ovf),
    .o_sticky_err (o_sticky_err),
    .i_clr_status (i_clr_status),
    .o_op_count   (o_op_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    int sa, sb, d, n, idx;
    logic [3:0] a4, b4;
    logic [7:0] v8;
    logic [15:0] v16;
    r = '0;
    a4 = a[3:0];
    b4 = b[3:0];
    case (op)
      2'd0: begin
        sa = int'($signed(a4));
        sb = int'($signed(b4));
        d = sa - sb;
        r.y = d[3:0];
        r.ovf = (d > 7) || (d < -8);
      end
      2'd1: r.y = ~(a4 & b4);
      2'd2: begin
        v8 = {b4, a4};
        n = 0;
        while (n < 8 && v8[7 - n]) n++;
        r.y = n[3:0];
        r.ovf = n > 15;
      end
      default: begin
        v16 = {b, a};
        idx = 0;
        for (int i = 15; i >= 0; i--) if (v16[i]) idx = i;
        r.y = idx[3:0];
        r.ovf = idx > 15;
        r.err = $countones(v16) > 1;
      end
    endcase
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after o_valid rises
  task automatic present(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit clr_in_exec, output exp_t e);
    chk("ready_idle", o_ready, 1);
    i_valid = 1'b1;
    i_op = op;
    i_a = a;
    i_b = b;
    sb_q.push_back(model(op, a, b));
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("valid_exec", o_valid, 0);
    chk("ready_exec", o_ready, 0);
    if (clr_in_exec) i_clr_status = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_clr_status = 1'b0;
    exp_count = exp_count + 8'd1;
    chk("valid_done", o_valid, 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '0;
    chk("y", o_y, e.y);
    chk("overflow", o_overflow, e.ovf);
    chk("err", o_err, e.err);
  endtask

  task automatic release_done();
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("valid_drop", o_valid, 0);
    chk("ready_back", o_ready, 1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    present(op, a, b, 1'b0, e);
    release_done();
  endtask

  task automatic pulse_clr();
    i_clr_status = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_clr_status = 1'b0;
  endtask

  initial begin
    exp_t e;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_clr_status = 1'b0;
    i_op = 2'd0;
    i_a = 8'd0;
    i_b = 8'd0;
    exp_count = 8'd0;

    @(negedge i_clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_y", o_y, 0);
    chk("rst_flags", {o_overflow, o_err, o_sticky_ovf, o_sticky_err}, 0);
    chk("rst_count", o_op_count, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_op(2'd0, 8'h07, 8'h0F);
    chk("sticky_ovf_set", o_sticky_ovf, 1);
    chk("count_1", o_op_count, exp_count);
    pulse_clr();
    chk("sticky_ovf_clr", o_sticky_ovf, 0);

    run_op(2'd1, 8'h0C, 8'h0A);
    run_op(2'd2, 8'h0C, 8'h0F);
    run_op(2'd3, 8'h00, 8'h01);
    chk("sticky_err_clean", o_sticky_err, 0);
    run_op(2'd3, 8'h03, 8'h00);
    chk("sticky_err_set", o_sticky_err, 1);
    run_op(2'd1, 8'h05, 8'h03);
    chk("sticky_err_held", o_sticky_err, 1);
    pulse_clr();
    chk("sticky_err_clr", o_sticky_err, 0);

    // Clear coincident with the EXEC->DONE edge: the new flag must win
    present(2'd3, 8'h81, 8'h00, 1'b1, e);
    chk("clr_vs_set", o_sticky_err, 1);
    release_done();
    chk("count_mid", o_op_count, exp_count);

    // Back-pressure in DONE with a competing request on the input
    present(2'd1, 8'h05, 8'h03, 1'b0, held);
    i_valid = 1'b1;
    i_op = 2'd0;
    i_a = 8'h0E;
    i_b = 8'h01;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("hold_valid", o_valid, 1);
      chk("hold_y", o_y, held.y);
      chk("hold_flags", {o_overflow, o_err}, {held.ovf, held.err});
      chk("hold_ready", o_ready, 0);
    end
    i_valid = 1'b0;
    release_done();
    repeat (3) begin
      @(negedge i_clk);
      chk("no_ghost_op", o_valid, 0);
    end
    chk("count_after_hold", o_op_count, exp_count);

    // Reset abandons an operation in EXEC
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_count = 8'd0;
    sb_q.delete();
    @(negedge i_clk);
    i_valid = 1'b1;
    i_op = 2'd3;
    i_a = 8'h03;
    i_b = 8'h00;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("pre_rst_exec", o_ready, 0);
    i_rst_n = 1'b0;
    #1;
    chk("arst_ready", o_ready, 1);
    chk("arst_valid", o_valid, 0);
    chk("arst_out", {o_y, o_overflow, o_err, o_sticky_ovf, o_sticky_err}, 0);
    chk("arst_count", o_op_count, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("post_rst_idle", {o_valid, o_ready}, 2'b01);
    end
    chk("post_rst_count", o_op_count, 0);
    chk("post_rst_sticky", {o_sticky_ovf, o_sticky_err}, 0);

    // 256 completed operations wrap the counter
    for (int n = 0; n < 256; n++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      if (n == 254) chk("count_255", o_op_count, 255);
    end
    chk("count_wrap", o_op_count, 0);
    chk("count_model", o_op_count, exp_count);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
